pwm_capture: RTL

- Two-channel PWM input capture unit, the receive-side counterpart of the team's PWM generator.
- Measures high time and period of external PWM signals, e.g. RC receiver outputs or servo feedback.
- Measurements are in system-clock cycles.
- Reads and control go through the same custom-instruction interface as the other CPU custom blocks (start/ciN/valueA/valueB/done/result).

---
 rtl/pwm_capture.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: two-channel PWM input capture (high time and period, in clock
// cycles) read and controlled through the CPU custom-instruction port.
// Optional glitch filter on each input: define PWM_CAPTURE_FILTER_EN.

module pwm_capture_ch #(
   parameter int unsigned      CNT_W      = 20,
   parameter logic [CNT_W-1:0] TIMEOUT    = '1,
   parameter int unsigned      FILTER_LEN = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pin,
   input  logic             en,
   input  logic             clr_valid,
   input  logic             clr_stale,
   output logic             level,
   output logic [CNT_W-1:0] width,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stale
);
   typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n, shadow_q, shadow_n, width_n, period_n;
   logic             valid_n, stale_n;
   logic             s1, s2, src, src_d, rise, fall;

   // two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   assign level = s2;

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int unsigned    FW   = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0]  FMAX = FW'(FILTER_LEN - 1);
   logic          filt, filt_d;
   logic [FW-1:0] fcnt;

   // glitch filter: follow s2 only once it has disagreed for FILTER_LEN cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         filt   <= 1'b0;
         filt_d <= 1'b0;
         fcnt   <= '0;
      end else begin
         filt_d <= filt;
         if (s2 != filt) begin
            if (fcnt == FMAX) begin
               filt <= s2;
               fcnt <= '0;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   assign src   = filt;
   assign src_d = filt_d;
`else
   localparam int unsigned flen_unused = FILTER_LEN;
   logic s3;

   // third flop holds the previous level for edge detection
   always_ff @(posedge clock) begin
      if (reset) s3 <= 1'b0;
      else       s3 <= s2;
   end

   assign src   = s2;
   assign src_d = s3;
`endif

   assign rise = src & ~src_d;
   assign fall = ~src & src_d;

   // state and measurement registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ARM;
         cnt_q    <= '0;
         shadow_q <= '0;
         width    <= '0;
         period   <= '0;
         valid    <= 1'b0;
         stale    <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         shadow_q <= shadow_n;
         width    <= width_n;
         period   <= period_n;
         valid    <= valid_n;
         stale    <= stale_n;
      end
   end

   // next state: disable, then timeout, take precedence over edges; a capture
   // overrides a same-cycle clear-on-read of valid
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      shadow_n = shadow_q;
      width_n  = width;
      period_n = period;
      valid_n  = valid & ~clr_valid;
      stale_n  = stale & ~clr_stale;
      if (!en) begin
         state_n = ARM;
         cnt_n   = '0;
         valid_n = 1'b0;
      end else if (state_q != ARM && cnt_q == TIMEOUT) begin
         state_n = ARM;
         cnt_n   = '0;
         valid_n = 1'b0;
         stale_n = 1'b1;
      end else begin
         case (state_q)
            HIGH: begin
               cnt_n = cnt_q + 1'b1;
               if (fall) begin
                  shadow_n = cnt_q;
                  state_n  = LOW;
               end
            end
            LOW: begin
               cnt_n = cnt_q + 1'b1;
               if (rise) begin
                  width_n  = shadow_q;
                  period_n = cnt_q;
                  valid_n  = 1'b1;
                  stale_n  = 1'b0;
                  cnt_n    = CNT_W'(1);
                  state_n  = HIGH;
               end
            end
            default: begin
               cnt_n = '0;
               if (rise) begin
                  cnt_n   = CNT_W'(1);
                  state_n = HIGH;
               end
            end
         endcase
      end
   end
endmodule

module pwm_capture #(
   parameter logic [7:0]       customId   = 8'h00,
   parameter int unsigned      CNT_W      = 20,
   parameter logic [CNT_W-1:0] TIMEOUT    = 20'hFFFFF,
   parameter logic [1:0]       EN_RESET   = 2'b11,
   parameter int unsigned      FILTER_LEN = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   input  logic [1:0]  pwmIn,
   output logic        done,
   output logic [31:0] result
);
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] sel;
   } ci_req_t;

   ci_req_t                 req;
   logic                    accept;
   logic [1:0]              en, clr_valid, clr_stale, level_a, valid_a, stale_a;
   logic [1:0][CNT_W-1:0]   width_a, period_a;
   logic [31:0]             status, rd_data;
   logic                    unused_bits;

   assign req         = valueA[3:0];
   assign accept      = start && (ciN == customId);
   assign clr_stale   = (accept && req.op == 2'b11) ? valueB[3:2] : 2'b00;
   assign status      = {24'b0, level_a, en, stale_a, valid_a};
   assign unused_bits = ^{valueA[31:4], valueB[31:4]};

   for (genvar g = 0; g < 2; g++) begin : g_ch
      assign clr_valid[g] = accept && req.op == 2'b01 && req.sel == 2'(g);

      pwm_capture_ch #(
         .CNT_W      (CNT_W),
         .TIMEOUT    (TIMEOUT),
         .FILTER_LEN (FILTER_LEN)
      ) u_ch (
         .clock     (clock),
         .reset     (reset),
         .pin       (pwmIn[g]),
         .en        (en[g]),
         .clr_valid (clr_valid[g]),
         .clr_stale (clr_stale[g]),
         .level     (level_a[g]),
         .width     (width_a[g]),
         .period    (period_a[g]),
         .valid     (valid_a[g]),
         .stale     (stale_a[g])
      );
   end

   // read mux; channel selects 2/3 read as zero, control returns old status
   always_comb begin
      rd_data = '0;
      case (req.op)
         2'b00:   if (!req.sel[1]) rd_data = 32'(width_a[req.sel[0]]);
         2'b01:   if (!req.sel[1]) rd_data = 32'(period_a[req.sel[0]]);
         default: rd_data = status;
      endcase
   end

   // response register and enable mask; every accepted start answers next cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
         en     <= EN_RESET;
      end else begin
         done   <= accept;
         result <= accept ? rd_data : 32'd0;
         if (accept && req.op == 2'b11) en <= valueB[1:0];
      end
   end
endmodule
